// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: ID-stage hazard detection with a register scoreboard for a multi-cycle unit
module pipeline_scoreboard #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [3:0]  id_rd,
    input  logic        id_multicycle,
    input  logic        idex_memread,
    input  logic [3:0]  idex_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [3:0]  mul_rd,
    output logic [15:0] pending
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [3:0]  mul_rd_nx;
    logic [15:0] pending_nx;
    logic        load_use, sb_raw, sb_waw, struct_hz, stall, issue;

    assign load_use  = idex_memread & ((id_uses_rs & (idex_rt == id_rs)) | (id_uses_rt & (idex_rt == id_rt)));
    assign sb_raw    = (id_uses_rs & pending[id_rs]) | (id_uses_rt & pending[id_rt]);
    assign sb_waw    = pending[id_rd];
    assign mul_busy  = (state == BUSY);
    assign mul_done  = mul_busy & (cnt == 3'd0);
    assign struct_hz = id_multicycle & mul_busy & ~mul_done;
    assign stall     = id_valid & (load_use | sb_raw | sb_waw | struct_hz);
    assign issue     = id_valid & id_multicycle & ~stall & ~branch_taken;

    assign ifid_flush  = branch_taken;
    assign idex_bubble = branch_taken | stall;
    assign pc_write    = branch_taken | ~stall;
    assign ifid_write  = branch_taken | ~stall;

    // Multi-cycle unit sequencing: an issue (re)loads the countdown, done returns to idle
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mul_rd_nx = mul_rd;
        if (issue) begin
            state_nx  = BUSY;
            cnt_nx    = CNT_LOAD;
            mul_rd_nx = id_rd;
        end else if (mul_done) begin
            state_nx = IDLE;
        end else if (mul_busy) begin
            cnt_nx = cnt - 3'd1;
        end
    end

    // Scoreboard: retire the finishing destination, then mark the newly issued one so set wins
    always_comb begin
        pending_nx = pending & ~(mul_done ? 16'(1) << mul_rd : 16'h0000);
        pending_nx = pending_nx | (issue ? 16'(1) << id_rd : 16'h0000);
    end

    // State, counter, destination and scoreboard registers; reset abandons any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            mul_rd  <= 4'd0;
            pending <= 16'h0000;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mul_rd  <= mul_rd_nx;
            pending <= pending_nx;
        end
    end
endmodule
